// File: rtl/pipeout_block_stager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipeout_block_stager                                          |
// | Purpose  : Ping-pong staging of FIFO words into whole blocks for         |
// |            a block-throttled pipe-out endpoint.                          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pipeout_block_stager #(
  parameter int BLOCK_WORDS = 256,
  parameter int CNT_W       = 32
) (
  input  logic             rd_clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [31:0]      fifo_dout,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  output logic             fifo_rd_en,
  output logic             ep_ready,
  input  logic             ep_read,
  input  logic             ep_blockstrobe,
  output logic [31:0]      ep_datain,
  output logic [CNT_W-1:0] blocks_sent,
  output logic             underrun
);

  localparam int              c_AW   = $clog2(BLOCK_WORDS);
  localparam logic [c_AW-1:0] c_LAST = c_AW'(BLOCK_WORDS - 1);
  localparam logic [c_AW:0]   c_BLK  = (c_AW + 1)'(BLOCK_WORDS);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FILLING  = 2'd1,
    ST_FULL     = 2'd2,
    ST_DRAINING = 2'd3
  } buf_st_t;

  logic [31:0]      r_mem [0:2*BLOCK_WORDS-1];
  buf_st_t          r_st  [2];
  buf_st_t          w_nst [2];
  logic             r_fill_ptr;
  logic             r_drain_ptr;
  logic             r_inflight;
  logic [c_AW-1:0]  r_fill_cnt;
  logic [c_AW-1:0]  r_rd_cnt;
  logic             r_ep_ready;
  logic             r_underrun;
  logic [31:0]      r_ep_datain;
  logic [CNT_W-1:0] r_blocks_sent;

  logic w_fill_open;
  logic w_room;
  logic w_rd_en;
  logic w_cap;
  logic w_cap_last;
  logic w_drain_ok;
  logic w_drain;
  logic w_drain_last;
  logic w_unused;

  // Block-start strobe carries no information the buffer states don't already have.
  assign w_unused = ep_blockstrobe;

  assign w_fill_open  = (r_st[r_fill_ptr] == ST_EMPTY) || (r_st[r_fill_ptr] == ST_FILLING);
  assign w_room       = ({1'b0, r_fill_cnt} + {{c_AW{1'b0}}, r_inflight}) < c_BLK;
  assign w_rd_en      = rstn & enable & ~fifo_empty & w_fill_open & w_room;
  assign w_cap        = fifo_valid & r_inflight;
  assign w_cap_last   = w_cap & (r_fill_cnt == c_LAST);
  assign w_drain_ok   = (r_st[r_drain_ptr] == ST_FULL) || (r_st[r_drain_ptr] == ST_DRAINING);
  assign w_drain      = ep_read & w_drain_ok;
  assign w_drain_last = w_drain & (r_rd_cnt == c_LAST);

  // Fill and drain never touch the same buffer in one cycle, so both updates can apply.
  always_comb begin
    w_nst[0] = r_st[0];
    w_nst[1] = r_st[1];
    if (w_rd_en && (r_st[r_fill_ptr] == ST_EMPTY)) w_nst[r_fill_ptr] = ST_FILLING;
    if (w_cap_last)                                w_nst[r_fill_ptr] = ST_FULL;
    if (w_drain) w_nst[r_drain_ptr] = w_drain_last ? ST_EMPTY : ST_DRAINING;
  end

  always_ff @(posedge rd_clk) begin
    if (w_cap) r_mem[{r_fill_ptr, r_fill_cnt}] <= fifo_dout;
  end

  always_ff @(posedge rd_clk or negedge rstn) begin
    if (!rstn) begin
      r_st[0]       <= ST_EMPTY;
      r_st[1]       <= ST_EMPTY;
      r_fill_ptr    <= 1'b0;
      r_drain_ptr   <= 1'b0;
      r_inflight    <= 1'b0;
      r_fill_cnt    <= '0;
      r_rd_cnt      <= '0;
      r_ep_ready    <= 1'b0;
      r_underrun    <= 1'b0;
      r_ep_datain   <= '0;
      r_blocks_sent <= '0;
    end else begin
      r_st[0] <= w_nst[0];
      r_st[1] <= w_nst[1];

      if (w_rd_en)         r_inflight <= 1'b1;
      else if (fifo_valid) r_inflight <= 1'b0;

      if (w_cap) begin
        r_fill_cnt <= w_cap_last ? '0 : r_fill_cnt + c_AW'(1);
        if (w_cap_last) r_fill_ptr <= ~r_fill_ptr;
      end

      if (w_drain) begin
        r_ep_datain <= r_mem[{r_drain_ptr, r_rd_cnt}];
        r_rd_cnt    <= w_drain_last ? '0 : r_rd_cnt + c_AW'(1);
        if (w_drain_last) begin
          r_drain_ptr   <= ~r_drain_ptr;
          r_blocks_sent <= r_blocks_sent + CNT_W'(1);
        end
      end else if (ep_read) begin
        r_underrun <= 1'b1;
      end

      // A DRAINING buffer always has words left; it goes EMPTY on its final read.
      r_ep_ready <= (w_nst[0] == ST_FULL) || (w_nst[1] == ST_FULL) ||
                    (w_nst[0] == ST_DRAINING) || (w_nst[1] == ST_DRAINING);
    end
  end

  assign fifo_rd_en  = w_rd_en;
  assign ep_ready    = r_ep_ready;
  assign ep_datain   = r_ep_datain;
  assign blocks_sent = r_blocks_sent;
  assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_pipeout_block_stager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipeout_block_stager                                       |
// | Purpose  : Self-checking bench: FIFO model, block host, stream model.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pipeout_block_stager;

  localparam int BW = 256;

  logic        rd_clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_valid;
  logic        fifo_rd_en;
  logic        ep_ready;
  logic        ep_read;
  logic        ep_blockstrobe;
  logic [31:0] ep_datain;
  logic [31:0] blocks_sent;
  logic        underrun;

  always #5 rd_clk = ~rd_clk;

  pipeout_block_stager #(.BLOCK_WORDS(BW), .CNT_W(32)) dut (
    .rd_clk         (rd_clk),
    .rstn           (rstn),
    .enable         (enable),
    .fifo_dout      (fifo_dout),
    .fifo_empty     (fifo_empty),
    .fifo_valid     (fifo_valid),
    .fifo_rd_en     (fifo_rd_en),
    .ep_ready       (ep_ready),
    .ep_read        (ep_read),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_datain      (ep_datain),
    .blocks_sent    (blocks_sent),
    .underrun       (underrun)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] fq[$];
  logic [31:0] capq[$];
  int          cap_total;
  int          rd_total;
  logic [31:0] exp_dat;
  logic        exp_und;
  int          stall_pct = 0;
  bit          raw_mode = 1'b1;
  bit          chk_on = 1'b0;
  bit          rand_en = 1'b0;

  typedef struct {
    logic        en, rd, bs, emp, vld;
    logic [31:0] dout;
    logic        x_rden, x_rdy, x_und;
    logic [31:0] x_dat, x_bs;
  } rst_vec_t;

  rst_vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cap_total = 0;
    rd_total  = 0;
    exp_dat   = '0;
    exp_und   = 1'b0;
    capq.delete();
    fq.delete();
  endtask

  // One clock: check post-edge outputs at negedge, then advance the reference
  // stream model and the FIFO model just after the next posedge.
  task automatic step();
    logic        s_rd, s_read, s_valid, s_empty;
    logic [31:0] s_dout;
    @(negedge rd_clk);
    if (chk_on && rstn) begin
      chk("ep_datain", ep_datain, exp_dat);
      chk("ep_ready", 32'(ep_ready), 32'((cap_total / BW) > (rd_total / BW)));
      chk("blocks_sent", blocks_sent, 32'(rd_total / BW));
      chk("underrun", 32'(underrun), 32'(exp_und));
      chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
      chk("rd_en_while_disabled", 32'(fifo_rd_en & ~enable), 32'd0);
    end
    s_rd    = fifo_rd_en;
    s_read  = ep_read;
    s_valid = fifo_valid;
    s_empty = fifo_empty;
    s_dout  = fifo_dout;
    @(posedge rd_clk);
    #1;
    if (rstn) begin
      // A read is served only when the block it belongs to is fully captured.
      if (s_read) begin
        if ((rd_total / BW) < (cap_total / BW)) begin
          exp_dat = capq[rd_total];
          rd_total++;
        end else begin
          exp_und = 1'b1;
        end
      end
      if (s_valid) begin
        capq.push_back(s_dout);
        cap_total++;
      end
    end
    if (!raw_mode) begin
      if (rstn && s_rd && !s_empty && fq.size() > 0) begin
        fifo_dout  = fq.pop_front();
        fifo_valid = 1'b1;
      end else begin
        fifo_valid = 1'b0;
      end
      fifo_empty = (fq.size() == 0) || ($urandom_range(99) < stall_pct);
    end
    if (rand_en) enable = ($urandom_range(3) != 0);
  endtask

  task automatic wait_ready(input int limit);
    for (int i = 0; i < limit && !ep_ready; i++) step();
    chk("ep_ready_wait", 32'(ep_ready), 32'd1);
  endtask

  task automatic read_block();
    wait_ready(5000);
    ep_read        = 1'b1;
    ep_blockstrobe = 1'b1;
    step();
    ep_blockstrobe = 1'b0;
    repeat (BW - 1) step();
    ep_read = 1'b0;
  endtask

  task automatic push_range(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 32'(i));
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; ep_read = 1'b0; ep_blockstrobe = 1'b0;
    fifo_dout = '0; fifo_empty = 1'b1; fifo_valid = 1'b0;
    model_reset();

    // Inputs toggled while reset is held: every output must stay at its reset value.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
    for (int v = 0; v < 6; v++) begin
      enable = vecs[v].en; ep_read = vecs[v].rd; ep_blockstrobe = vecs[v].bs;
      fifo_empty = vecs[v].emp; fifo_valid = vecs[v].vld; fifo_dout = vecs[v].dout;
      step();
      chk("rst_fifo_rd_en", 32'(fifo_rd_en), 32'(vecs[v].x_rden));
      chk("rst_ep_ready", 32'(ep_ready), 32'(vecs[v].x_rdy));
      chk("rst_underrun", 32'(underrun), 32'(vecs[v].x_und));
      chk("rst_ep_datain", ep_datain, vecs[v].x_dat);
      chk("rst_blocks_sent", blocks_sent, vecs[v].x_bs);
    end

    raw_mode = 1'b0; enable = 1'b0; ep_read = 1'b0; ep_blockstrobe = 1'b0;
    fifo_empty = 1'b1; fifo_valid = 1'b0; fifo_dout = '0;
    step();
    rstn = 1'b1;
    model_reset();
    chk_on = 1'b1;
    step();

    // Single block
    push_range(32'd0, BW);
    enable = 1'b1;
    read_block();
    repeat (3) step();
    chk("t2_ep_datain", ep_datain, 32'd255);
    chk("t2_blocks_sent", blocks_sent, 32'd1);
    chk("t2_ep_ready", 32'(ep_ready), 32'd0);

    // Ping-pong over four blocks
    push_range(32'd0, 4 * BW);
    for (int b = 0; b < 4; b++) read_block();
    repeat (3) step();
    chk("t3_ep_datain", ep_datain, 32'd1023);
    chk("t3_blocks_sent", blocks_sent, 32'd5);
    chk("t3_underrun", 32'(underrun), 32'd0);

    // Random empty stalls and enable drops
    stall_pct = 40;
    rand_en   = 1'b1;
    push_range(32'd0, 2 * BW);
    for (int b = 0; b < 2; b++) read_block();
    rand_en   = 1'b0;
    enable    = 1'b1;
    stall_pct = 0;
    repeat (3) step();
    chk("t4_ep_datain", ep_datain, 32'd511);
    chk("t4_blocks_sent", blocks_sent, 32'd7);

    // Underrun: nothing staged
    ep_read = 1'b1;
    step();
    ep_read = 1'b0;
    step();
    chk("t5_underrun", 32'(underrun), 32'd1);
    chk("t5_ep_datain", ep_datain, 32'd511);
    chk("t5_blocks_sent", blocks_sent, 32'd7);

    // Reset after 100 reads of a block, then a clean refill
    push_range(32'h2000, BW);
    wait_ready(5000);
    ep_read = 1'b1;
    repeat (100) step();
    ep_read = 1'b0;
    rstn = 1'b0;
    model_reset();
    fifo_valid = 1'b0;
    fifo_empty = 1'b1;
    repeat (2) step();
    chk("t6_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t6_ep_ready", 32'(ep_ready), 32'd0);
    chk("t6_ep_datain", ep_datain, 32'd0);
    chk("t6_blocks_sent", blocks_sent, 32'd0);
    chk("t6_underrun", 32'(underrun), 32'd0);
    rstn = 1'b1;
    step();
    push_range(32'h1000, BW);
    read_block();
    repeat (3) step();
    chk("t6_last_word", ep_datain, 32'h0000_10FF);
    chk("t6_blocks_after", blocks_sent, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
